wb_write_arbiter: RTL
=====================

// Module: wb_write_arbiter
// PURPOSE
//  Writer side of the register-file write port. Merges in-order write-backs from the
//  main pipeline WB stage with out-of-order results from the multiply/divide unit (MDU).
//  Pipeline writes go straight through. MDU results are buffered in a FIFO and drained
//  on idle port cycles. Exports a pending-register mask to the hazard unit.
// PARAMETERS
//  DEPTH        4   MDU result FIFO entries (power of 2, >=2)
//  STARVE_LIMIT 8   full-and-blocked cycles before drain stall is requested (guard only)
// PORTS
//  clk            in   1   clock, rising edge
//  reset          in   1   asynchronous, active-high reset
//  pipe_we        in   1   WB stage write enable
//  pipe_rd        in   5   WB stage destination register
//  pipe_data      in   32  WB stage write data
//  mdu_valid      in   1   MDU result valid
//  mdu_ready      out  1   FIFO can accept; transfer when mdu_valid & mdu_ready
//  mdu_rd         in   5   MDU destination register
//  mdu_data       in   32  MDU result
//  RegWrite       out  1   to register file write enable
//  Write_register out  5   to register file write address
//  Write_data     out  32  to register file write data
//  pend_mask      out  32  bit r = 1 when a live FIFO entry targets register r
//  stall_req      out  1   drain-priority request to hazard unit (0 without guard)
// BEHAVIOUR
//  - Reset: FIFO empty, all entries dead, counters 0; mdu_ready=1, RegWrite=0,
//    Write_register=0, Write_data=0, pend_mask=0, stall_req=0.
//  - Port outputs are combinational, same cycle as inputs; the register file commits at clk.
//  - Port select: pipe_we & pipe_rd!=0 & !stall_req -> pipeline write. Otherwise, if the
//    FIFO head is live -> head write, pop at clk. Otherwise RegWrite=0.
//  - When RegWrite=0, Write_register=0 (no false bypass match). Write_data is don't-care.
//  - pipe_we with pipe_rd==0: no write, and the port counts as idle (FIFO may drain).
//  - MDU push: mdu_valid & mdu_ready. mdu_ready = !full. No push when full, even if a pop
//    occurs that cycle. Push with mdu_rd==0 is accepted and discarded (not enqueued).
//  - Min latency push->RegWrite = 1 cycle. A result never bypasses an empty FIFO.
//  - WAW kill: a pipeline write to rd clears the live bit of every FIFO entry with that rd
//    (the pipeline write is younger). A same-cycle push to the same rd is NOT killed
//    (the MDU result is younger).
//  - Dead head: popped in one cycle with RegWrite=0 from the FIFO side. The pipeline may
//    still write in that cycle.
//  - pend_mask is the OR of live entries, registered. It reflects pushes, kills and pops
//    from the cycle after they occur.
//  - Count is DEPTH-wide+1. Pointers wrap modulo DEPTH. Push and pop in the same cycle
//    leave the count unchanged.
// CONFIGURATION
//  WB_ARB_STARVE_GUARD_EN defined:
//   - A counter increments each cycle in which the FIFO is full and the pipeline holds the port.
//   - It clears on any pop.
//   - At count==STARVE_LIMIT, stall_req=1 (registered). The head is then written instead of
//     the pipeline, and the hazard unit holds WB, so the pipe write is retried.
//   - stall_req drops after that pop.
//  Undefined: stall_req tied 0 and the FIFO may starve indefinitely.
// STRUCTURE
//  - Shared package regfile_pkg:
//    - REG_ADDR_W=5, REG_DATA_W=32, REG_ZERO=5'd0
//    - typedef wb_req_t {live, rd, data}
//  - Sub-module wb_result_fifo: circular buffer of wb_req_t with per-entry kill-by-rd and
//    a live-mask output.
//  - Top level: port mux and (optionally) the starvation counter.
// TESTING
//  1. Reset mid-drain, with FIFO holding 3 entries -> next cycle pend_mask=0, mdu_ready=1,
//     RegWrite=0.
//  2. Push rd=5 data=0x11 with pipe idle -> next cycle RegWrite=1, Write_register=5,
//     Write_data=0x11. The cycle after, pend_mask[5]=0.
//  3. Push rd=7 while the pipe writes continuously, then pipe write rd=7 0xAA -> entry killed,
//     pend_mask[7]=0. When the pipe idles, the head pops with RegWrite=0 and r7 is never
//     written with the MDU data.
//  4. DEPTH+1 pushes with the pipe busy -> mdu_ready=0 after DEPTH accepts. The 5th is held.
//     After one idle cycle, mdu_ready=1.
//  5. Push rd=0 and pipe_we with pipe_rd=0 -> no RegWrite, count unchanged, pend_mask=0.
//  6. (guard) FIFO full, pipe_we=1 for 8 cycles -> stall_req=1, then head written and
//     stall_req=0 the next cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file write-port types: address/data widths and the write-back request record.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int REG_COUNT  = 2 ** REG_ADDR_W;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                  live;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

  function automatic logic [REG_COUNT-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
    logic [REG_COUNT-1:0] mask;
    mask     = '0;
    mask[rd] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Circular buffer of MDU write-back requests with per-entry kill-by-rd and a live-register mask.
module wb_result_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  wb_req_t               push_req,
  input  logic                  pop,
  input  logic                  kill_en,
  input  logic [REG_ADDR_W-1:0] kill_rd,
  output wb_req_t               head,
  output logic                  empty,
  output logic                  full,
  output logic [REG_COUNT-1:0]  live_mask
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  wb_req_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);
  assign head  = mem[rd_ptr];

  // NOTE: the live bits must come out of reset cleared; the payload is cleared with them so
  // Write_data never carries X from an unwritten slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      // NOTE: non-blocking updates to one slot resolve last-write-wins, so a same-cycle push
      // overrides the kill for its own slot (the MDU result is the younger write).
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en && mem[i].rd == kill_rd) mem[i].live <= 1'b0;
      end
      if (pop) begin
        mem[rd_ptr].live <= 1'b0;
        rd_ptr           <= rd_ptr + 1'b1;
      end
      if (push) begin
        mem[wr_ptr] <= push_req;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Freed slots are always dead, so the mask can OR every slot without a range check.
  always_comb begin
    live_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i].live) live_mask |= rd_onehot(mem[i].rd);
    end
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: pipeline WB writes pass straight through, MDU results drain on
// idle cycles. Optional starvation guard enabled by defining WB_ARB_STARVE_GUARD_EN.
module wb_write_arbiter
  import regfile_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pipe_we,
  input  logic [REG_ADDR_W-1:0] pipe_rd,
  input  logic [REG_DATA_W-1:0] pipe_data,
  input  logic                  mdu_valid,
  output logic                  mdu_ready,
  input  logic [REG_ADDR_W-1:0] mdu_rd,
  input  logic [REG_DATA_W-1:0] mdu_data,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] Write_register,
  output logic [REG_DATA_W-1:0] Write_data,
  output logic [REG_COUNT-1:0]  pend_mask,
  output logic                  stall_req
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 2");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end

  wb_req_t head;
  logic    fifo_empty;
  logic    fifo_full;
  logic    fifo_push;
  logic    fifo_pop;
  logic    pipe_sel;
  logic    head_write;

  // Writes to r0 never reach the file, so they leave the port idle for the FIFO.
  assign pipe_sel   = pipe_we && (pipe_rd != REG_ZERO) && !stall_req;
  assign head_write = !fifo_empty && head.live && !pipe_sel;
  assign fifo_pop   = !fifo_empty && (!head.live || !pipe_sel);
  assign mdu_ready  = !fifo_full;
  assign fifo_push  = mdu_valid && mdu_ready && (mdu_rd != REG_ZERO);

  // NOTE: every output gets a default first so no path through this block infers a latch.
  always_comb begin
    RegWrite       = 1'b0;
    Write_register = REG_ZERO;
    Write_data     = '0;
    if (pipe_sel) begin
      RegWrite       = 1'b1;
      Write_register = pipe_rd;
      Write_data     = pipe_data;
    end else if (head_write) begin
      RegWrite       = 1'b1;
      Write_register = head.rd;
      Write_data     = head.data;
    end
  end

  wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_req  ('{live: 1'b1, rd: mdu_rd, data: mdu_data}),
    .pop       (fifo_pop),
    .kill_en   (pipe_sel),
    .kill_rd   (pipe_rd),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .live_mask (pend_mask)
  );

`ifdef WB_ARB_STARVE_GUARD_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_cnt;

  // Saturates at the limit; the forced head write pops and clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (fifo_pop) begin
      starve_cnt <= '0;
    end else if (fifo_full && pipe_sel && starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign stall_req = (starve_cnt == STARVE_MAX);
`else
  assign stall_req = 1'b0;
`endif

endmodule
